matrix_buffer_ctrl: RTL and testbench

Sequencing controller in front of the 8x8 ping-pong transpose buffer. Accepts a raw row stream with a frame-start marker and generates the buffer's row-valid, start-of-block, end-of-block and start-of-frame strobes, guaranteeing exactly 8 rows per block. It admits a block only when a bank and the downstream consumer are available, counts blocks per frame, and flags framing errors.

---
 rtl/matrix_ctrl_pkg.sv | 15 +
 rtl/mbc_stats.sv | 21 ++
 rtl/matrix_buffer_ctrl.sv | 124 ++++++++++++
 tb/tb_matrix_buffer_ctrl.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/matrix_ctrl_pkg.sv
// Shared constants and types for the 8x8 ping-pong transpose buffer sequencing controller.
package matrix_ctrl_pkg;

  localparam int ROWS_PER_BLOCK = 8;
  localparam int NUM_BANKS      = 2;
  localparam int ROW_W          = $clog2(ROWS_PER_BLOCK);
  // Drain counter must hold ROWS_PER_BLOCK itself, hence the +1.
  localparam int DRAIN_W        = $clog2(ROWS_PER_BLOCK + 1);

  typedef enum logic {
    S_IDLE,
    S_FILL
  } state_t;

endpackage

// File: rtl/mbc_stats.sv
// Free-running wrap-around statistics counters for matrix_buffer_ctrl (completed blocks, stalled cycles).
module mbc_stats (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        blk_inc,
  input  logic        stall_inc,
  output logic [31:0] stat_blocks,
  output logic [31:0] stat_stalls
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_blocks <= '0;
      stat_stalls <= '0;
    end else begin
      if (blk_inc)   stat_blocks <= stat_blocks + 32'd1;
      if (stall_inc) stat_stalls <= stat_stalls + 32'd1;
    end
  end

endmodule

// File: rtl/matrix_buffer_ctrl.sv
// Row sequencer for the 8x8 ping-pong transpose buffer: block/frame strobes, bank admission, framing errors.
// Optional statistics counters are built when MATRIX_BUFFER_CTRL_STATS_EN is defined.
module matrix_buffer_ctrl
  import matrix_ctrl_pkg::*;
#(
  parameter int BPF_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             up_valid,
  input  logic             up_sof,
  output logic             up_ready,
  input  logic [BPF_W-1:0] cfg_blocks,
  input  logic             dn_ready,
  input  logic             err_clr,
  output logic             mb_valid,
  output logic             mb_sob,
  output logic             mb_eob,
  output logic             mb_sof,
  output logic [BPF_W-1:0] blk_idx,
  output logic             frame_done,
  output logic             err_sof,
  output logic             busy,
  output logic [31:0]      stat_blocks,
  output logic [31:0]      stat_stalls
);

  state_t             state, state_nxt;
  logic [ROW_W-1:0]   row_cnt;
  logic [BPF_W-1:0]   bpf_q;
  logic [1:0]         outstanding;
  logic [DRAIN_W-1:0] drain_cnt;
  logic               accept;
  logic               first_row;
  logic               last_row;
  logic               drain_done;
  logic               sof_err;

  assign accept     = up_valid & up_ready;
  assign first_row  = (state == S_IDLE) && (blk_idx == '0);
  assign last_row   = (state == S_FILL) && (row_cnt == ROW_W'(ROWS_PER_BLOCK - 1));
  assign drain_done = (drain_cnt == DRAIN_W'(1));
  assign sof_err    = accept & (up_sof != first_row);

  always_comb begin
    state_nxt  = state;
    up_ready   = 1'b0;
    mb_valid   = accept;
    mb_sob     = 1'b0;
    mb_eob     = 1'b0;
    mb_sof     = 1'b0;
    frame_done = 1'b0;
    case (state)
      S_IDLE: begin
        // A new block is only admitted when a bank is free and the consumer can take a full burst.
        up_ready = dn_ready & (outstanding < 2'(NUM_BANKS));
        if (up_valid & up_ready) begin
          mb_sob    = 1'b1;
          mb_sof    = first_row;
          state_nxt = S_FILL;
        end
      end
      S_FILL: begin
        up_ready = 1'b1;
        if (up_valid & last_row) begin
          mb_eob     = 1'b1;
          frame_done = (blk_idx >= bpf_q - BPF_W'(1));
          state_nxt  = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      row_cnt <= '0;
      blk_idx <= '0;
      bpf_q   <= BPF_W'(1);
      err_sof <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) row_cnt <= row_cnt + ROW_W'(1);
      if (mb_eob) blk_idx <= frame_done ? '0 : blk_idx + BPF_W'(1);
      if (mb_sof) bpf_q <= (cfg_blocks == '0) ? BPF_W'(1) : cfg_blocks;
      if (err_clr)      err_sof <= 1'b0;
      else if (sof_err) err_sof <= 1'b1;
    end
  end

  // Bank drain model: each completed block unloads over the 8 cycles following its eob.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drain_cnt   <= '0;
      outstanding <= '0;
    end else begin
      if (mb_eob)              drain_cnt <= DRAIN_W'(ROWS_PER_BLOCK);
      else if (drain_cnt != 0) drain_cnt <= drain_cnt - DRAIN_W'(1);
      case ({mb_eob, drain_done})
        2'b10:   if (outstanding != 2'(NUM_BANKS)) outstanding <= outstanding + 2'd1;
        2'b01:   if (outstanding != 2'd0) outstanding <= outstanding - 2'd1;
        default: outstanding <= outstanding;
      endcase
    end
  end

  assign busy = (state == S_FILL) | (outstanding != 2'd0);

`ifdef MATRIX_BUFFER_CTRL_STATS_EN
  mbc_stats u_stats (
    .clk         (clk),
    .rst_n       (rst_n),
    .blk_inc     (mb_eob),
    .stall_inc   (up_valid & ~up_ready),
    .stat_blocks (stat_blocks),
    .stat_stalls (stat_stalls)
  );
`else
  assign stat_blocks = '0;
  assign stat_stalls = '0;
`endif

endmodule

// File: tb/tb_matrix_buffer_ctrl.sv
// Self-checking bench for matrix_buffer_ctrl: directed scenarios plus randomized traffic against a row/block-level model.
module tb_matrix_buffer_ctrl;

  localparam int BPF_W = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             up_valid = 1'b0;
  logic             up_sof = 1'b0;
  logic             dn_ready = 1'b0;
  logic             err_clr = 1'b0;
  logic [BPF_W-1:0] cfg_blocks = '0;
  logic             up_ready, mb_valid, mb_sob, mb_eob, mb_sof, frame_done, err_sof, busy;
  logic [BPF_W-1:0] blk_idx;
  logic [31:0]      stat_blocks, stat_stalls;

  matrix_buffer_ctrl #(.BPF_W(BPF_W)) dut (
    .clk(clk), .rst_n(rst_n), .up_valid(up_valid), .up_sof(up_sof), .up_ready(up_ready),
    .cfg_blocks(cfg_blocks), .dn_ready(dn_ready), .err_clr(err_clr), .mb_valid(mb_valid),
    .mb_sob(mb_sob), .mb_eob(mb_eob), .mb_sof(mb_sof), .blk_idx(blk_idx),
    .frame_done(frame_done), .err_sof(err_sof), .busy(busy),
    .stat_blocks(stat_blocks), .stat_stalls(stat_stalls)
  );

  always #5 clk = ~clk;

  // Reference model state: rows accepted in the current block, block number, frame length, error flag.
  int m_rows, m_blk, m_bpf, m_cyc;
  bit m_err;
  int eob_q[$];
  int m_stat_blocks, m_stat_stalls;
  int checks = 0;
  int passes = 0;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("[TB] FAIL %s got=%0h expected=%0h at cycle %0d", tag, got, exp, m_cyc);
  endtask

  // A bank is occupied from the cycle after its eob through the 8 cycles it takes to unload.
  function automatic int outstandingNow();
    int n = 0;
    foreach (eob_q[i]) if (eob_q[i] < m_cyc && m_cyc <= eob_q[i] + 8) n++;
    return n;
  endfunction

  function automatic bit wantSof();
    return (m_rows == 0) && (m_blk == 0);
  endfunction

  task automatic resetModel();
    m_rows = 0; m_blk = 0; m_bpf = 1; m_err = 1'b0;
    eob_q.delete();
    m_stat_blocks = 0; m_stat_stalls = 0;
  endtask

  task automatic applyStimulus(input bit v, input bit s, input bit d, input bit c,
                               input logic [BPF_W-1:0] cfg);
    bit idle, exp_ready, acc, first, eob, fd;
    int outs;
    @(negedge clk);
    up_valid = v; up_sof = s; dn_ready = d; err_clr = c; cfg_blocks = cfg;
    #1;
    idle      = (m_rows == 0);
    outs      = outstandingNow();
    exp_ready = idle ? (d && outs < 2) : 1'b1;
    acc       = v && exp_ready;
    first     = idle && (m_blk == 0);
    eob       = acc && (m_rows == 7);
    fd        = eob && (m_blk == m_bpf - 1);
    checkOutput("up_ready",   32'(up_ready),   32'(exp_ready));
    checkOutput("mb_valid",   32'(mb_valid),   32'(acc));
    checkOutput("mb_sob",     32'(mb_sob),     32'(acc && idle));
    checkOutput("mb_eob",     32'(mb_eob),     32'(eob));
    checkOutput("mb_sof",     32'(mb_sof),     32'(acc && first));
    checkOutput("frame_done", 32'(frame_done), 32'(fd));
    checkOutput("blk_idx",    32'(blk_idx),    32'(m_blk));
    checkOutput("err_sof",    32'(err_sof),    32'(m_err));
    checkOutput("busy",       32'(busy),       32'(!idle || outs > 0));
`ifdef MATRIX_BUFFER_CTRL_STATS_EN
    checkOutput("stat_blocks", stat_blocks, 32'(m_stat_blocks));
    checkOutput("stat_stalls", stat_stalls, 32'(m_stat_stalls));
`else
    checkOutput("stat_blocks", stat_blocks, 32'd0);
    checkOutput("stat_stalls", stat_stalls, 32'd0);
`endif
    @(posedge clk);
    if (v && !exp_ready) m_stat_stalls++;
    if (c) m_err = 1'b0;
    else if (acc && (s != first)) m_err = 1'b1;
    if (acc) begin
      if (first) m_bpf = (cfg == 0) ? 1 : int'(cfg);
      m_rows = (m_rows + 1) % 8;
      if (eob) begin
        eob_q.push_back(m_cyc);
        m_stat_blocks++;
        m_blk = fd ? 0 : m_blk + 1;
      end
    end
    m_cyc++;
    while (eob_q.size() > 0 && eob_q[0] + 8 < m_cyc) void'(eob_q.pop_front());
  endtask

  task automatic doReset();
    @(negedge clk);
    #2;
    rst_n = 1'b0; up_valid = 1'b0; up_sof = 1'b0; dn_ready = 1'b0; err_clr = 1'b0;
    #1;
    checkOutput("rst_up_ready",   32'(up_ready),   32'd0);
    checkOutput("rst_mb_valid",   32'(mb_valid),   32'd0);
    checkOutput("rst_mb_sob",     32'(mb_sob),     32'd0);
    checkOutput("rst_mb_eob",     32'(mb_eob),     32'd0);
    checkOutput("rst_mb_sof",     32'(mb_sof),     32'd0);
    checkOutput("rst_frame_done", 32'(frame_done), 32'd0);
    checkOutput("rst_blk_idx",    32'(blk_idx),    32'd0);
    checkOutput("rst_err_sof",    32'(err_sof),    32'd0);
    checkOutput("rst_busy",       32'(busy),       32'd0);
    checkOutput("rst_stat_blocks", stat_blocks,    32'd0);
    checkOutput("rst_stat_stalls", stat_stalls,    32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    resetModel();
  endtask

  task automatic runRows(input int n, input logic [BPF_W-1:0] cfg, input int err_row);
    for (int i = 0; i < n; i++) applyStimulus(1'b1, wantSof() ^ (i == err_row), 1'b1, 1'b0, cfg);
  endtask

  task automatic runIdle(input int n, input logic [BPF_W-1:0] cfg);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, cfg);
  endtask

  task automatic runToFrameStart(input logic [BPF_W-1:0] cfg);
    for (int i = 0; i < 200 && !wantSof(); i++) applyStimulus(1'b1, wantSof(), 1'b1, 1'b0, cfg);
  endtask

  initial begin
    m_cyc = 0;
    resetModel();
    doReset();

    // Two-block frame streamed continuously.
    runRows(16, 16'd2, -1);
    runIdle(3, 16'd2);

    // Consumer not ready at block start, then released.
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, wantSof(), 1'b0, 1'b0, 16'd2);
    applyStimulus(1'b1, wantSof(), 1'b1, 1'b0, 16'd2);
    runRows(7, 16'd2, -1);

    // Three blocks back-to-back, then let the banks drain.
    runRows(24, 16'd3, -1);
    runIdle(12, 16'd3);

    // Misplaced frame start on row 3, sticky until cleared, clear beats a new error.
    runToFrameStart(16'd2);
    runRows(8, 16'd2, 3);
    runIdle(3, 16'd2);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 16'd2);
    applyStimulus(1'b1, !wantSof(), 1'b1, 1'b1, 16'd2);
    runIdle(2, 16'd2);

    // Zero blocks per frame behaves as one.
    runToFrameStart(16'd0);
    runRows(24, 16'd0, -1);
    runIdle(10, 16'd0);

    // Randomized traffic with occasional framing errors and clears.
    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(0, 99) < 70,
                    wantSof() ^ ($urandom_range(0, 99) < 5),
                    $urandom_range(0, 99) < 60,
                    $urandom_range(0, 99) < 5,
                    BPF_W'($urandom_range(0, 3)));
    end

    // Reset in the middle of a block, then restart cleanly.
    for (int i = 0; i < 100 && m_rows != 4; i++) applyStimulus(1'b1, wantSof(), 1'b1, 1'b0, 16'd2);
    doReset();
    runRows(16, 16'd2, -1);
    runIdle(10, 16'd2);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
